adc_frame_averager: RTL and testbench

//   Downstream of the MAX11046 read sequencer. Captures the 16-bit words the sequencer latches off DB
//   on each RD pulse and tags them with a channel index (0..NUM_CH-1) within each conversion frame.

---
 rtl/adc_frame_averager_if.sv | 14 +
 rtl/adc_frame_averager.sv | 171 +++++++++++++++++
 tb/tb_adc_frame_averager.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_averager_if.sv
// rtl/adc_frame_averager_if.sv - averaged-frame output stream, one channel per beat
interface adc_frame_averager_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 3
);
    logic              valid;
    logic              ready;
    logic [CH_W-1:0]   channel;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, channel, data, last, input ready);
    modport slave  (input valid, channel, data, last, output ready);
endinterface

// File: rtl/adc_frame_averager.sv
// rtl/adc_frame_averager.sv - tags sequencer words by channel, averages 2^AVG_LOG2 frames, streams the result
module adc_frame_averager #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 16,
    parameter int AVG_LOG2    = 4,
    parameter int SIGNED_DATA = 1
) (
    input  logic                clock_i,
    input  logic                rst_i,
    input  logic                frame_start_i,
    input  logic                sample_valid_i,
    input  logic [DATA_W-1:0]   sample_data_i,
    adc_frame_averager_if.master out_if,
    output logic                overrun_o,
    output logic                frame_error_o
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Sequencer strobes are registered once before the capture FSM sees them.
    logic              in_fs_q, in_sv_q;
    logic [DATA_W-1:0] in_data_q;

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              seen_q, seen_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              overrun_q, overrun_d;
    logic              frame_error_q, frame_error_d;

    logic [DATA_W-1:0] staging_q [NUM_CH];
    logic [ACC_W-1:0]  acc_q     [NUM_CH];
    logic [DATA_W-1:0] bank_q    [NUM_CH];
    logic [ACC_W-1:0]  sum       [NUM_CH];

    logic              wr_en, commit, snap, hs, last_hs, bank_load;
    logic [CH_W-1:0]   wr_idx;

    function automatic logic [ACC_W-1:0] extend(input logic [DATA_W-1:0] s);
        if (SIGNED_DATA != 0)
            return ACC_W'($signed(s));
        else
            return ACC_W'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            sum[i] = acc_q[i] + extend(staging_q[i]);
    end

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        frame_cnt_d   = frame_cnt_q;
        seen_d        = seen_q;
        out_valid_d   = out_valid_q;
        out_ch_d      = out_ch_q;
        overrun_d     = overrun_q;
        frame_error_d = frame_error_q;

        wr_idx = in_fs_q ? '0 : ch_q;
        wr_en  = in_sv_q && (in_fs_q || state_q == ST_FILL);
        commit = (state_q == ST_COMMIT);
        snap   = commit && (frame_cnt_q == LAST_FRAME);

        // frame_start restarts the fill from any state; a commit in flight still completes
        if (in_fs_q || state_q == ST_FILL) begin
            if (wr_en && wr_idx == LAST_CH) begin
                state_d = ST_COMMIT;
                ch_d    = '0;
            end else begin
                state_d = ST_FILL;
                ch_d    = wr_en ? wr_idx + CH_W'(1) : wr_idx;
            end
        end else begin
            state_d = ST_WAIT;
            ch_d    = '0;
        end

        if (in_fs_q) begin
            seen_d = 1'b0;
            if (state_q == ST_FILL)
                frame_error_d = 1'b1;
        end else if (commit) begin
            seen_d = 1'b1;
            if (in_sv_q)
                frame_error_d = 1'b1;
        end else if (state_q == ST_WAIT && in_sv_q && seen_q) begin
            frame_error_d = 1'b1;
        end

        if (commit)
            frame_cnt_d = snap ? '0 : frame_cnt_q + FC_W'(1);

        hs        = out_valid_q && out_if.ready;
        last_hs   = hs && (out_ch_q == LAST_CH);
        bank_load = snap && (!out_valid_q || last_hs);

        if (snap && !bank_load)
            overrun_d = 1'b1;

        if (bank_load) begin
            out_valid_d = 1'b1;
            out_ch_d    = '0;
        end else if (hs) begin
            out_ch_d = last_hs ? '0 : out_ch_q + CH_W'(1);
            if (last_hs)
                out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            in_fs_q       <= 1'b0;
            in_sv_q       <= 1'b0;
            in_data_q     <= '0;
            state_q       <= ST_WAIT;
            ch_q          <= '0;
            frame_cnt_q   <= '0;
            seen_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                staging_q[i] <= '0;
                acc_q[i]     <= '0;
                bank_q[i]    <= '0;
            end
        end else begin
            in_fs_q       <= frame_start_i;
            in_sv_q       <= sample_valid_i;
            in_data_q     <= sample_data_i;
            state_q       <= state_d;
            ch_q          <= ch_d;
            frame_cnt_q   <= frame_cnt_d;
            seen_q        <= seen_d;
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
            if (wr_en)
                staging_q[wr_idx] <= in_data_q;
            if (commit) begin
                for (int i = 0; i < NUM_CH; i++)
                    acc_q[i] <= snap ? '0 : sum[i];
            end
            // Dropping the low AVG_LOG2 bits of the extended sum is the floor divide.
            if (bank_load) begin
                for (int i = 0; i < NUM_CH; i++)
                    bank_q[i] <= sum[i][ACC_W-1:AVG_LOG2];
            end
        end
    end

    assign out_if.valid   = out_valid_q;
    assign out_if.channel = out_ch_q;
    assign out_if.data    = bank_q[out_ch_q];
    assign out_if.last    = out_valid_q && (out_ch_q == LAST_CH);
    assign overrun_o      = overrun_q;
    assign frame_error_o  = frame_error_q;
endmodule

// File: tb/tb_adc_frame_averager.sv
// tb/tb_adc_frame_averager.sv - scoreboard bench for adc_frame_averager
module tb_adc_frame_averager;
    localparam int NUM_CH   = 8;
    localparam int AVG_LOG2 = 2;
    localparam int NFRAMES  = 1 << AVG_LOG2;

    typedef logic [15:0] frame_t [NUM_CH];

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        rst_u = 1'b1;
    logic        frame_start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        overrun, frame_error, overrun_u, frame_error_u;

    adc_frame_averager_if #(.DATA_W(16), .CH_W(3)) out_m ();
    adc_frame_averager_if #(.DATA_W(16), .CH_W(3)) out_u ();

    adc_frame_averager #(.NUM_CH(NUM_CH), .DATA_W(16), .AVG_LOG2(AVG_LOG2), .SIGNED_DATA(1)) dut_s (
        .clock_i(clock), .rst_i(rst), .frame_start_i(frame_start), .sample_valid_i(sample_valid),
        .sample_data_i(sample_data), .out_if(out_m), .overrun_o(overrun), .frame_error_o(frame_error));

    adc_frame_averager #(.NUM_CH(NUM_CH), .DATA_W(16), .AVG_LOG2(AVG_LOG2), .SIGNED_DATA(0)) dut_u (
        .clock_i(clock), .rst_i(rst_u), .frame_start_i(frame_start), .sample_valid_i(sample_valid),
        .sample_data_i(sample_data), .out_if(out_u), .overrun_o(overrun_u), .frame_error_o(frame_error_u));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [19:0] exp_q[$];
    logic [19:0] exp_u[$];
    int m_acc[NUM_CH];
    int u_acc[NUM_CH];
    int m_cnt = 0;
    int u_cnt = 0;
    bit u_on = 1'b0;
    bit exp_ovr = 1'b0;
    int rdy_mode = 0;

    function automatic logic [19:0] pack(input int ch, input int avg);
        return {(ch == NUM_CH - 1), 3'(ch), 16'(avg)};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset;
        exp_q.delete();
        m_cnt = 0;
        exp_ovr = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
    endtask

    task automatic model_commit(input frame_t w);
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] += int'($signed(w[i]));
            if (u_on) u_acc[i] += int'(w[i]);
        end
        m_cnt++;
        if (m_cnt == NFRAMES) begin
            if (exp_q.size() != 0)
                exp_ovr = 1'b1;
            else
                for (int i = 0; i < NUM_CH; i++) exp_q.push_back(pack(i, m_acc[i] >>> AVG_LOG2));
            m_cnt = 0;
            for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
        end
        if (u_on) begin
            u_cnt++;
            if (u_cnt == NFRAMES) begin
                for (int i = 0; i < NUM_CH; i++) exp_u.push_back(pack(i, u_acc[i] >>> AVG_LOG2));
                u_cnt = 0;
                for (int i = 0; i < NUM_CH; i++) u_acc[i] = 0;
            end
        end
    endtask

    task automatic drive_frame(input int n, input frame_t w, input bit chk_lat);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = w[i];
            tick();
        end
        sample_valid = 1'b0;
        if (n == NUM_CH) model_commit(w);
        tick();
        if (chk_lat) check_eq("latency_edge1_low", out_m.valid, 1'b0);
        tick();
        if (chk_lat) check_eq("latency_edge2_high", out_m.valid, 1'b1);
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && (exp_q.size() != 0 || exp_u.size() != 0); i++) tick();
        check_eq({tag, "_drained"}, exp_q.size() + exp_u.size(), 0);
        check_eq({tag, "_idle"}, out_m.valid, 1'b0);
    endtask

    task automatic stray_strobe;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
    endtask

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: out_m.ready = 1'b1;
            1: out_m.ready = 1'b0;
            default: out_m.ready = ~out_m.ready;
        endcase
    end

    bit          stall_prev = 1'b0;
    logic [15:0] s_data;
    logic [2:0]  s_ch;
    logic [19:0] e_m, e_u;

    always @(negedge clock) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("stall_valid", out_m.valid, 1'b1);
                check_eq("stall_data", out_m.data, s_data);
                check_eq("stall_channel", out_m.channel, s_ch);
            end
            if (out_m.valid && out_m.ready) begin
                check_eq("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e_m = exp_q.pop_front();
                    check_eq("beat_channel", out_m.channel, e_m[18:16]);
                    check_eq("beat_data", out_m.data, e_m[15:0]);
                    check_eq("beat_last", out_m.last, e_m[19]);
                end
            end
            stall_prev = out_m.valid && !out_m.ready;
            s_data = out_m.data;
            s_ch   = out_m.channel;
        end
        if (!rst_u && out_u.valid) begin
            check_eq("u_beat_expected", exp_u.size() != 0, 1'b1);
            if (exp_u.size() != 0) begin
                e_u = exp_u.pop_front();
                check_eq("u_beat_channel", out_u.channel, e_u[18:16]);
                check_eq("u_beat_data", out_u.data, e_u[15:0]);
                check_eq("u_beat_last", out_u.last, e_u[19]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_t w;
        out_m.ready = 1'b1;
        out_u.ready = 1'b1;
        model_reset();
        for (int i = 0; i < NUM_CH; i++) u_acc[i] = 0;
        repeat (3) tick();
        check_eq("rst_out_valid", out_m.valid, 1'b0);
        check_eq("rst_out_channel", out_m.channel, 3'd0);
        check_eq("rst_out_data", out_m.data, 16'd0);
        check_eq("rst_out_last", out_m.last, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_frame_error", frame_error, 1'b0);
        rst = 1'b0;
        tick();

        stray_strobe();
        check_eq("wait_strobe_no_error", frame_error, 1'b0);

        // T1: ch k = 100k+f
        for (int f = 0; f < NFRAMES; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'(100 * k + f);
            drive_frame(NUM_CH, w, f == NFRAMES - 1);
        end
        drain("t1", 60);
        check_eq("t1_overrun", overrun, exp_ovr);

        // T2: signed floor rounding, ch0 = -3,-2,-2,-2
        for (int f = 0; f < NFRAMES; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'(-700 * k + 3 * f);
            w[0] = (f == 0) ? 16'hFFFD : 16'hFFFE;
            drive_frame(NUM_CH, w, 1'b0);
        end
        drain("t2", 60);

        // T2b: signed vs offset-binary instance on the same words
        rst_u = 1'b0;
        u_on = 1'b1;
        tick();
        for (int f = 0; f < NFRAMES; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'hFFFF;
            w[1] = (f == 0) ? 16'hFFFF : 16'h0000;
            drive_frame(NUM_CH, w, 1'b0);
        end
        drain("t2b", 60);
        rst_u = 1'b1;
        u_on = 1'b0;
        check_eq("t2b_pre_overrun", overrun, 1'b0);

        // T3: consumer stalled across two more averaged frames
        rdy_mode = 1;
        tick();
        for (int f = 0; f < 3 * NFRAMES; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'(20 * k + 9 * f + 1);
            drive_frame(NUM_CH, w, 1'b0);
        end
        check_eq("t3_overrun", overrun, exp_ovr);
        check_eq("t3_bank_channel", out_m.channel, 3'd0);
        check_eq("t3_bank_hold", out_m.data, exp_q[0][15:0]);
        rdy_mode = 0;
        drain("t3", 60);

        // T4: short frame then complete frames
        check_eq("t4_pre_frame_error", frame_error, 1'b0);
        for (int k = 0; k < NUM_CH; k++) w[k] = 16'h7000;
        drive_frame(5, w, 1'b0);
        for (int f = 0; f < NFRAMES; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'(50 * k + 7 * f);
            drive_frame(NUM_CH, w, 1'b0);
        end
        check_eq("t4_frame_error", frame_error, 1'b1);
        drain("t4", 60);

        // T5: ready toggling every cycle
        rdy_mode = 2;
        for (int f = 0; f < NFRAMES; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'(11 * k + 300 * f);
            drive_frame(NUM_CH, w, 1'b0);
        end
        drain("t5", 100);
        rdy_mode = 0;
        tick();

        // T6: reset while beat 3 is presented
        for (int f = 0; f < NFRAMES; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'(k + 1000 * f);
            drive_frame(NUM_CH, w, 1'b0);
        end
        for (int i = 0; i < 50 && exp_q.size() > 5; i++) tick();
        check_eq("t6_at_beat3", out_m.channel, 3'd3);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_valid", out_m.valid, 1'b0);
        check_eq("t6_rst_overrun", overrun, 1'b0);
        check_eq("t6_rst_frame_error", frame_error, 1'b0);
        model_reset();
        rst = 1'b0;
        tick();
        for (int f = 0; f < NFRAMES - 1; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k] = 16'(13 * k + 40 * f);
            drive_frame(NUM_CH, w, 1'b0);
        end
        repeat (10) tick();
        check_eq("t6_no_early_output", out_m.valid, 1'b0);
        for (int k = 0; k < NUM_CH; k++) w[k] = 16'(13 * k + 40 * (NFRAMES - 1));
        drive_frame(NUM_CH, w, 1'b0);
        drain("t6", 60);

        stray_strobe();
        check_eq("long_frame_error", frame_error, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
